// File: rtl/lsu_mem_port.sv
// Load/store port between the core control FSM and a synchronous data memory.
// One request in flight: lane-aligns stores, waits MEM_LATENCY for loads, then extends the returned lane.
module lsu_mem_port #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [1:0]        fsm_state
);

    localparam int BW = XLEN / 8;
    localparam int OW = $clog2(BW);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and responses are single-cycle pulses with no backpressure.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [OW-1:0]   off_q;
    logic [CW-1:0]   cnt;

    logic [OW-1:0]   req_off;
    logic            illegal;
    logic            misaligned;
    logic            req_err;
    logic [BW-1:0]   size_mask;
    logic [XLEN-1:0] rdata_shift;
    logic [XLEN-1:0] load_data;

    assign req_off   = req_addr[OW-1:0];
    assign req_ready = (state == IDLE) && !reset;
    assign fsm_state = state;

    always_comb begin
        illegal = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
        if (XLEN == 32) begin
            illegal = illegal || (req_funct3 == 3'b011) || (req_funct3 == 3'b110);
        end
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b00:   size_mask = BW'(1);
            2'b01:   size_mask = BW'(3);
            2'b10:   size_mask = BW'(15);
            default: size_mask = '1;
        endcase
        req_err = illegal || misaligned;
    end

    // Truncate to the access size, then fill the upper bits with the sign or with zeros.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] s, input logic [2:0] f3);
        logic [XLEN-1:0] mask;
        logic            sbit;
        case (f3[1:0])
            2'b00:   begin mask = XLEN'(8'hFF);         sbit = s[7];      end
            2'b01:   begin mask = XLEN'(16'hFFFF);      sbit = s[15];     end
            2'b10:   begin mask = XLEN'(32'hFFFF_FFFF); sbit = s[31];     end
            default: begin mask = '1;                   sbit = s[XLEN-1]; end
        endcase
        return (s & mask) | ((sbit && !f3[2]) ? ~mask : '0);
    endfunction

    assign rdata_shift = mem_rdata >> {off_q, 3'b000};
    assign load_data   = extend(rdata_shift, f3_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= '0;
            cnt        <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q  <= req_we;
                        f3_q  <= req_funct3;
                        off_q <= req_off;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            // Memory-side outputs are loaded here so they come straight from flops in ISSUE.
                            state     <= ISSUE;
                            mem_en    <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                            mem_be    <= size_mask << req_off;
                            mem_wdata <= req_wdata << {req_off, 3'b000};
                        end
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end else begin
                        state <= WAIT;
                        cnt   <= CW'(MEM_LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Parametrised multicycle load/store unit between the processor control FSM and synchronous data memory. It accepts one load or store request at a time and aligns store data onto byte lanes with byte enables. For loads it waits a configurable memory latency, then extracts and sign- or zero-extends the returned lane. It replaces ad-hoc address/data muxing in the core with a handshaked port that supports byte, halfword, word and, at XLEN=64, doubleword accesses.

## Interface
- XLEN, 32: data width, 32 or 64.
- ADDR_W, 32: byte-address width.
- MEM_LATENCY, 1: cycles from the mem_en cycle to mem_rdata valid, ≥1.

Clock and reset: one clock; reset is asynchronous and active-high (`clk`, `reset`).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; request accepted when valid&ready.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V width/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, LSB-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal access; valid with resp_valid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write strobe, only with mem_en.
- mem_addr  out  ADDR_W  XLEN/8-aligned address (low log2(XLEN/8) bits 0).
- mem_be  out  XLEN/8  byte enables.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_rdata  in  XLEN  read data.

## Operation
- funct3 codes: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only).
- Illegal codes: 111 always; 011/110 at XLEN=32; any funct3[2]=1 with req_we=1.
- Misaligned: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0.
- Errors: illegal or misaligned → no memory access; resp_err=1.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On handshake, register we/funct3/addr/wdata. If error → RESP with err flag set; else → ISSUE.
- ISSUE: mem_en=1 and mem_we=we for exactly this cycle.
  - mem_be: size mask shifted by lane offset = addr mod XLEN/8.
  - mem_wdata: wdata shifted left by 8×offset.
  - Store → RESP. Load → WAIT with counter = MEM_LATENCY−1 (→ RESP-capture directly when MEM_LATENCY=1).
- WAIT: decrement counter. In the cycle the counter is 0 (or the cycle after ISSUE when MEM_LATENCY=1), capture mem_rdata >> 8×offset; truncate to size; sign-extend for B/H/W, zero-extend for BU/HU/WU; → RESP.
- RESP: resp_valid=1 for one cycle, then → IDLE. No response backpressure; the consumer must sample.
- resp_rdata/resp_err hold until the next RESP; they are meaningful only with resp_valid.
- Single outstanding request; req_valid outside IDLE is ignored (not accepted).

## Timing
- Request accepted at edge ending cycle T.
- Error: resp_valid in cycle T+1.
- Store: mem_en in T+1; resp_valid in T+2.
- Load: mem_en in T+1; mem_rdata sampled at the edge ending T+MEM_LATENCY+1; resp_valid in T+MEM_LATENCY+2.
- Back-to-back: next request accepted in the cycle after RESP, giving a store throughput of 1 per 3 cycles.
- Reset values: state IDLE; mem_en, mem_we, resp_valid, resp_err = 0; mem_addr, mem_be, mem_wdata, resp_rdata = 0.
- req_ready=0 while reset is asserted, and 1 the first cycle after deassertion.
- Reset mid-operation: immediate return to IDLE; mem_en drops asynchronously; in-flight load data is discarded; no resp_valid is generated for the aborted request.
- mem_en, mem_we, mem_addr, mem_be and mem_wdata are driven from registered state only, with no combinational path from req_*.

## Test plan
- SW at XLEN=32, MEM_LATENCY=1, addr 0x104, data 0xDEADBEEF → T+1: mem_en=1, mem_we=1, mem_addr=0x104, mem_be=1111, mem_wdata=0xDEADBEEF; T+2: resp_valid=1, err=0.
- SB addr 0x203, data 0x000000A5 → mem_addr=0x200, mem_be=1000, mem_wdata=0xA5000000.
- LB and LBU at 0x202, mem_rdata=0x12F04455, MEM_LATENCY=3 → resp_valid at T+5; LB resp_rdata=0xFFFFFFF0; LBU resp_rdata=0x000000F0.
- LH at 0x101 → resp_valid at T+1, resp_err=1, mem_en never asserted. Opcode 111 and SB with funct3=100 behave the same.
- XLEN=64 LW at 0x...04, mem_rdata=0x80000001_00000000 → resp_rdata=0xFFFFFFFF_80000001. LWU of the same → 0x00000000_80000001.
- Assert reset during WAIT of a MEM_LATENCY=4 load → mem_en=0 and resp_valid=0 immediately. No resp_valid appears afterwards; req_ready=1 the first cycle after release.
